// File: rtl/txop_claim_table_ctrl.sv
// TXOP claim table (FREE/SOFT/HARD per id) with sweep clears and a round-robin free-entry pick.
// Ops 2-4 and illegal ops finish in 1 cycle; CLEAR_* take NUM_TXOP cycles; PICK_FREE 2..NUM_TXOP cycles; cmd_ready only when idle.
module txop_claim_table_ctrl #(
  parameter int NUM_TXOP = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_id,
  output logic       done,
  output logic       err,
  output logic [7:0] result_id,
  output logic       result_none,
  input  logic [7:0] q_id,
  output logic       hard_claiming,
  output logic       soft_claiming,
  output logic [7:0] max_hard_claim
);
  localparam int AW = $clog2(NUM_TXOP);
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] ONE      = IW'(1);
  localparam logic [IW-1:0] LAST     = IW'(NUM_TXOP - 1);
  localparam logic [IW-1:0] SCAN_END = IW'(NUM_TXOP - 2);
  localparam logic [8:0]    NUM9     = 9'(NUM_TXOP);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_SOFT = 2'd1;
  localparam logic [1:0] ST_HARD = 2'd2;

  typedef enum logic [2:0] {IDLE, SWEEP_ALL, SWEEP_SOFT, SCAN, FINISH} state_t;

  state_t        state_q, state_d;
  logic [1:0]    tbl_q [NUM_TXOP];
  logic [IW-1:0] idx_q, idx_d, cnt_q, cnt_d, ptr_q, ptr_d;
  logic          err_q, err_d, none_q, none_d;
  logic [7:0]    rid_q, rid_d, max_q, max_d;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [1:0]    wr_val;
  logic          accept, id_ok, q_ok;
  logic [1:0]    cmd_ent, idx_ent, q_ent;

  assign accept  = cmd_valid && cmd_ready;
  assign id_ok   = (cmd_id != 8'd0) && ({1'b0, cmd_id} < NUM9);
  assign cmd_ent = tbl_q[cmd_id[AW-1:0]];
  assign idx_ent = tbl_q[idx_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            3'd0:    state_d = SWEEP_ALL;
            3'd1:    state_d = SWEEP_SOFT;
            3'd5:    state_d = SCAN;
            default: state_d = FINISH;
          endcase
        end
      end
      SWEEP_ALL, SWEEP_SOFT: if (idx_q == LAST) state_d = FINISH;
      SCAN:    if (idx_ent == ST_FREE || cnt_q == SCAN_END) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath control: one table write per cycle at most, plus counter/result updates.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    rid_d  = rid_q;
    none_d = none_q;
    wr_en  = 1'b0;
    wr_idx = cmd_id[AW-1:0];
    wr_val = ST_FREE;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          idx_d = ONE;
          cnt_d = '0;
          case (cmd_op)
            3'd2, 3'd3, 3'd4: begin
              if (!id_ok) begin
                err_d = 1'b1;
              end else begin
                wr_en  = !(cmd_op == 3'd3 && cmd_ent == ST_HARD);
                wr_val = (cmd_op == 3'd2) ? ST_HARD : (cmd_op == 3'd3) ? ST_SOFT : ST_FREE;
              end
            end
            3'd5:       idx_d = ptr_q;
            3'd6, 3'd7: err_d = 1'b1;
            default: ;
          endcase
        end
      end
      SWEEP_ALL, SWEEP_SOFT: begin
        wr_idx = idx_q[AW-1:0];
        wr_en  = (state_q == SWEEP_ALL) || (idx_ent == ST_SOFT);
        idx_d  = idx_q + ONE;
      end
      SCAN: begin
        wr_idx = idx_q[AW-1:0];
        if (idx_ent == ST_FREE) begin
          wr_en  = 1'b1;
          wr_val = ST_SOFT;
          rid_d  = 8'(idx_q);
          none_d = 1'b0;
          ptr_d  = (idx_q == LAST) ? ONE : idx_q + ONE;
        end else if (cnt_q == SCAN_END) begin
          rid_d  = 8'd0;
          none_d = 1'b1;
        end else begin
          idx_d = (idx_q == LAST) ? ONE : idx_q + ONE;
          cnt_d = cnt_q + ONE;
        end
      end
      default: ;
    endcase
  end

  // Id 0 is never written, so its slot stays FREE and is overridden on the query side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TXOP; i++) tbl_q[i] <= ST_FREE;
    end else if (wr_en) begin
      tbl_q[wr_idx] <= wr_val;
    end
  end

  always_comb begin
    max_d = 8'd0;
    for (int i = 1; i < NUM_TXOP; i++) begin
      if (tbl_q[i] == ST_HARD) max_d = 8'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= ONE;
      cnt_q  <= '0;
      ptr_q  <= ONE;
      err_q  <= 1'b0;
      rid_q  <= 8'd0;
      none_q <= 1'b0;
      max_q  <= 8'd0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
      rid_q  <= rid_d;
      none_q <= none_d;
      max_q  <= max_d;
    end
  end

  assign cmd_ready      = reset_n && (state_q == IDLE);
  assign done           = (state_q == FINISH);
  assign err            = done && err_q;
  assign result_id      = rid_q;
  assign result_none    = none_q;
  assign max_hard_claim = max_q;

  assign q_ok          = ({1'b0, q_id} < NUM9);
  assign q_ent         = tbl_q[q_id[AW-1:0]];
  assign hard_claiming = q_ok && ((q_id == 8'd0) || (q_ent == ST_HARD));
  assign soft_claiming = q_ok && (q_id != 8'd0) && (q_ent == ST_SOFT);

endmodule

// File: tb/tb_txop_claim_table_ctrl.sv
// Scoreboard bench for txop_claim_table_ctrl: driver pushes model expectations, monitor checks each done pulse.
module tb_txop_claim_table_ctrl;
  localparam int N = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_id = 8'd0;
  logic [7:0] q_id = 8'd0;
  logic       cmd_ready, done, err, result_none, hard_claiming, soft_claiming;
  logic [7:0] result_id, max_hard_claim;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {int cyc; int err; int rid; int rnone;} exp_t;
  exp_t sb[$];
  exp_t mx;

  // Reference model: table contents as plain ints (0 free, 1 soft, 2 hard).
  int mt[N];
  int mptr = 1;
  int mrid = 0;
  int mnone = 0;

  txop_claim_table_ctrl #(.NUM_TXOP(N)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .done(done), .err(err),
    .result_id(result_id), .result_none(result_none), .q_id(q_id),
    .hard_claiming(hard_claiming), .soft_claiming(soft_claiming),
    .max_hard_claim(max_hard_claim)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mt[i] = 0;
    mptr = 1; mrid = 0; mnone = 0;
  endtask

  task automatic model_cmd(input int op, input int id, output int lat, output int e);
    e = 0;
    lat = 1;
    case (op)
      0: begin for (int i = 1; i < N; i++) mt[i] = 0; lat = N; end
      1: begin for (int i = 1; i < N; i++) if (mt[i] == 1) mt[i] = 0; lat = N; end
      2, 3, 4: begin
        if (id == 0 || id >= N) e = 1;
        else if (op == 2) mt[id] = 2;
        else if (op == 3) begin if (mt[id] != 2) mt[id] = 1; end
        else mt[id] = 0;
      end
      5: begin
        mnone = 1; mrid = 0; lat = N;
        for (int k = 0; k < N - 1; k++) begin
          int c;
          c = (mptr - 1 + k) % (N - 1) + 1;
          if (mt[c] == 0) begin
            mt[c] = 1; mrid = c; mnone = 0;
            mptr = c % (N - 1) + 1;
            lat = k + 2;
            break;
          end
        end
      end
      default: e = 1;
    endcase
  endtask

  task automatic issue(input int op, input int id);
    int n;
    int lat;
    int e;
    bit got;
    n = 0;
    got = 0;
    @(posedge clk); #1;
    cmd_op = 3'(op);
    cmd_id = 8'(id);
    cmd_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
      else n++;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    model_cmd(op, id, lat, e);
    sb.push_back('{last_acc + lat, e, mrid, mnone});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic qchk(input int id);
    int eh;
    int es;
    q_id = 8'(id);
    #1;
    eh = (id < N && (id == 0 || mt[id] == 2)) ? 1 : 0;
    es = (id < N && id != 0 && mt[id] == 1) ? 1 : 0;
    chk("hard_claiming", int'(hard_claiming), eh);
    chk("soft_claiming", int'(soft_claiming), es);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", sb.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_state();
    int m;
    m = 0;
    for (int i = 1; i < N; i++) if (mt[i] == 2) m = i;
    chk("max_hard_claim", int'(max_hard_claim), m);
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    qchk($urandom_range(1, N - 1));
    qchk($urandom_range(0, N + 8));
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (err && !done) chk("err_without_done", 1, 0);
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("missed_done", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mx = sb.pop_front();
          chk("done_cycle", cyc, mx.cyc);
          chk("err", int'(err), mx.err);
          chk("result_id", int'(result_id), mx.rid);
          chk("result_none", int'(result_none), mx.rnone);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int op;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_result_id", int'(result_id), 0);
    chk("rst_result_none", int'(result_none), 0);
    chk("rst_max", int'(max_hard_claim), 0);
    qchk(0);
    qchk(7);
    qchk(40);
    repeat (2) @(posedge clk);
    #1 chk("rst_cmd_ready_held", int'(cmd_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ready_after_reset", int'(cmd_ready), 1);

    // Round-robin picks from reset, then release 1 and pick again.
    repeat (3) issue(5, 0);
    issue(4, 1);
    issue(5, 0);
    wait_idle();
    check_state();
    for (int i = 1; i <= 4; i++) qchk(i);

    // Hard claims and max tracking.
    issue(2, 5);
    issue(2, 9);
    wait_idle();
    qchk(9);
    check_state();

    // CLEAR_SOFT keeps HARD, frees SOFT.
    issue(3, 3);
    issue(2, 4);
    issue(1, 0);
    wait_idle();
    qchk(3);
    qchk(4);
    check_state();

    // Rejected commands and no SOFT downgrade of a HARD entry.
    issue(2, 0);
    issue(2, 40);
    issue(7, 3);
    issue(6, 3);
    issue(3, 5);
    wait_idle();
    qchk(0);
    qchk(5);
    check_state();

    // Full table: pick must report none after a full lap; then a wrapping pick.
    for (int i = 1; i < N; i++) issue(2, i);
    issue(5, 0);
    wait_idle();
    check_state();
    issue(4, N - 1);
    issue(4, 2);
    issue(5, 0);
    issue(5, 0);
    issue(1, 0);
    wait_idle();
    check_state();
    issue(0, 0);
    wait_idle();
    check_state();

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) op = 0;
      else if (r < 6) op = 1;
      else if (r < 33) op = 2;
      else if (r < 53) op = 3;
      else if (r < 73) op = 4;
      else if (r < 95) op = 5;
      else op = $urandom_range(6, 7);
      issue(op, $urandom_range(0, N + 8));
      if (n % 10 == 9) begin
        wait_idle();
        check_state();
      end
    end
    wait_idle();

    // Reset during a CLEAR_TABLE sweep aborts with no done.
    issue(2, 20);
    issue(2, 3);
    wait_idle();
    issue(0, 0);
    while (cyc < last_acc + 10) @(posedge clk);
    #1 reset_n = 1'b0;
    sb.delete();
    model_reset();
    #2;
    chk("midrst_done", int'(done), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 0);
    chk("midrst_max", int'(max_hard_claim), 0);
    chk("midrst_result_id", int'(result_id), 0);
    qchk(20);
    qchk(0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ready_after_midrst", int'(cmd_ready), 1);
    issue(5, 0);
    issue(2, 7);
    wait_idle();
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
